hilo_muldiv_ctrl: RTL and testbench

- Multi-cycle multiply/divide sequencer that owns the 64-bit HI/LO register pair.
- Accepts one operation from the control unit and iterates a radix-2 shift-add multiply or restoring divide over WIDTH cycles.
- Presents the 64-bit result and pulses the HI/LO load enable for exactly one cycle.
- Sits between the control unit (start/op) and the HI/LO register (result, hilo_en).

---
 rtl/hilo_muldiv_ctrl_pkg.sv | 21 ++
 rtl/hilo_muldiv_ctrl_if.sv | 31 +++
 rtl/hilo_muldiv_ctrl_datapath.sv | 74 +++++++
 rtl/hilo_muldiv_ctrl.sv | 123 ++++++++++++
 tb/tb_hilo_muldiv_ctrl.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/hilo_muldiv_ctrl_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer.
package hilo_pkg;

  localparam int DEF_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MUL  = 2'b00,
    OP_MULU = 2'b01,
    OP_DIV  = 2'b10,
    OP_DIVU = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    RUN  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_e;

endpackage

// File: rtl/hilo_muldiv_ctrl_if.sv
// Control-unit <-> sequencer bus.
//
// Handshake: start is a request with no ready line. The sequencer samples
// start/op/a/b on a rising edge only while it can accept (busy=0, i.e. IDLE
// or the DONE cycle); a start seen while busy is dropped, never queued.
// Completion is the single-cycle done pulse; hilo_en (normal) or
// div_by_zero (b==0 divide) accompanies it, and result is valid from then
// until the next completion.
interface hilo_muldiv_ctrl_if #(
  parameter int WIDTH = hilo_pkg::DEF_WIDTH
);
  logic               start;
  logic [1:0]         op;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic               hilo_en;
  logic               div_by_zero;
  logic [2*WIDTH-1:0] result;

  modport master (
    output start, op, a, b,
    input  busy, done, hilo_en, div_by_zero, result
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, hilo_en, div_by_zero, result
  );
endinterface

// File: rtl/hilo_muldiv_ctrl_datapath.sv
// Shift/accumulate datapath: radix-2 shift-add multiply and restoring divide
// on unsigned magnitudes, plus the final sign correction.
module muldiv_datapath import hilo_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               is_div,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   load_lo,     // multiplier or dividend magnitude
  input  logic [WIDTH-1:0]   load_mcand,  // multiplicand or divisor magnitude
  input  logic               neg_prod,
  input  logic               neg_quo,
  input  logic               neg_rem,
  output logic [2*WIDTH-1:0] fixed
);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] hi;   // accumulator / partial remainder
  logic [WIDTH-1:0] lo;   // multiplier-product low half / quotient

  logic [WIDTH:0]   addend;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] hi_nxt;
  logic [WIDTH-1:0] lo_nxt;
  logic [2*WIDTH-1:0] prod;

  // One iteration of either algorithm; all sums are WIDTH+1 bits wide.
  always_comb begin
    addend  = lo[0] ? {1'b0, mcand} : '0;
    mul_sum = {1'b0, hi} + addend;
    rem_sh  = {hi, lo[WIDTH-1]};
    diff    = rem_sh - {1'b0, mcand};
    hi_nxt  = hi;
    lo_nxt  = lo;
    if (is_div) begin
      lo_nxt = {lo[WIDTH-2:0], ~diff[WIDTH]};
      hi_nxt = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
    end else begin
      hi_nxt = mul_sum[WIDTH:1];
      lo_nxt = {mul_sum[0], lo[WIDTH-1:1]};
    end
  end

  // Sign correction: 2W-bit product negated as a whole, quotient and
  // remainder negated independently.
  always_comb begin
    prod  = {hi, lo};
    fixed = neg_prod ? -prod : prod;
    if (is_div) begin
      fixed = {(neg_rem ? -hi : hi), (neg_quo ? -lo : lo)};
    end
  end

  // Operand load in PREP, one iteration per RUN cycle.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      mcand <= '0;
      hi    <= '0;
      lo    <= '0;
    end else if (load) begin
      mcand <= load_mcand;
      hi    <= '0;
      lo    <= load_lo;
    end else if (step) begin
      hi <= hi_nxt;
      lo <= lo_nxt;
    end
  end

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// Multi-cycle multiply/divide sequencer owning the HI/LO result.
// FSM IDLE -> PREP -> RUN (WIDTH cycles) -> FIX -> DONE; a b==0 divide
// skips straight from PREP to DONE.
module hilo_muldiv_ctrl import hilo_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                clk,
  input  logic                clr,
  hilo_muldiv_ctrl_if.slave   bus,
  output state_e              state
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, b_q;
  op_e                op_q;
  logic [CW-1:0]      cnt;
  logic               sgn_prod, sgn_quo, sgn_rem;
  logic [2*WIDTH-1:0] result_q;
  logic               busy_q, done_q, hilo_en_q, dbz_q;

  logic               accept;
  logic               is_signed, is_div, div0;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] fixed;

  // Operand decode from the latched request.
  always_comb begin
    is_signed = (op_q == OP_MUL) || (op_q == OP_DIV);
    is_div    = (op_q == OP_DIV) || (op_q == OP_DIVU);
    div0      = is_div && (b_q == '0);
    mag_a     = (is_signed && a_q[WIDTH-1]) ? -a_q : a_q;
    mag_b     = (is_signed && b_q[WIDTH-1]) ? -b_q : b_q;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: if (bus.start) begin
        state_d = PREP;
        accept  = 1'b1;
      end
      PREP:    state_d = div0 ? DONE : RUN;
      RUN:     if (cnt == LAST) state_d = FIX;
      FIX:     state_d = DONE;
      DONE: begin
        if (bus.start) begin
          state_d = PREP;
          accept  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, request latch, counter, sign flags and registered outputs.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= OP_MUL;
      cnt       <= '0;
      sgn_prod  <= 1'b0;
      sgn_quo   <= 1'b0;
      sgn_rem   <= 1'b0;
      result_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hilo_en_q <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      busy_q    <= (state_d == PREP) || (state_d == RUN) || (state_d == FIX);
      done_q    <= (state_d == DONE);
      // Only the PREP -> DONE edge is the divide-by-zero path.
      hilo_en_q <= (state_d == DONE) && (state_q != PREP);
      dbz_q     <= (state_d == DONE) && (state_q == PREP);
      if (accept) begin
        a_q  <= bus.a;
        b_q  <= bus.b;
        op_q <= op_e'(bus.op);
      end
      if (state_q == PREP) begin
        cnt      <= '0;
        sgn_prod <= is_signed && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
        sgn_quo  <= is_signed && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
        sgn_rem  <= is_signed && a_q[WIDTH-1];
        if (div0) result_q <= {a_q, {WIDTH{1'b1}}};
      end
      if (state_q == RUN) cnt <= cnt + CW'(1);
      if (state_q == FIX) result_q <= fixed;
    end
  end

  muldiv_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk        (clk),
    .clr        (clr),
    .is_div     (is_div),
    .load       (state_q == PREP),
    .step       (state_q == RUN),
    .load_lo    (is_div ? mag_a : mag_b),
    .load_mcand (is_div ? mag_b : mag_a),
    .neg_prod   (sgn_prod),
    .neg_quo    (sgn_quo),
    .neg_rem    (sgn_rem),
    .fixed      (fixed)
  );

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.hilo_en     = hilo_en_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.result      = result_q;
  assign state           = state_q;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Bench for hilo_muldiv_ctrl: directed cases plus randomized operations
// checked against an arithmetic reference model.
module tb_hilo_muldiv_ctrl;
  import hilo_pkg::*;

  localparam int W = 32;

  logic   clk;
  logic   clr;
  state_e state;

  hilo_muldiv_ctrl_if #(.WIDTH(W)) bus ();

  hilo_muldiv_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .clr   (clr),
    .bus   (bus),
    .state (state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [2*W-1:0] exp_q[$];
  logic           exp_dz_q[$];
  int             exp_lat_q[$];

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: plain 64-bit arithmetic on the operands.
  task automatic model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [2*W-1:0] res, output logic dz);
    longint          sa, sb, sq, sr;
    longint unsigned ua, ub;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    dz = 1'b0;
    res = '0;
    case (op)
      2'b00: res = sa * sb;
      2'b01: res = ua * ub;
      default: begin
        if (b == '0) begin
          dz  = 1'b1;
          res = {a, 32'hFFFF_FFFF};
        end else if (op == 2'b10) begin
          sq  = sa / sb;
          sr  = sa % sb;
          res = {sr[31:0], sq[31:0]};
        end else begin
          res = {32'(ua % ub), 32'(ua / ub)};
        end
      end
    endcase
  endtask

  // Present a request at a falling edge; it is sampled at the next rising
  // edge. Afterwards scramble the inputs to show they are not re-read.
  task automatic launch(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] res;
    logic           dz;
    model(op, a, b, res, dz);
    exp_q.push_back(res);
    exp_dz_q.push_back(dz);
    exp_lat_q.push_back(dz ? 1 : W + 2);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.op    = 2'($urandom_range(0, 3));
    bus.a     = $urandom;
    bus.b     = $urandom;
    check("busy_after_accept", 64'(bus.busy), 64'd1);
    check("done_low_after_accept", 64'(bus.done), 64'd0);
  endtask

  // Wait for done (bounded); k counts rising edges after the accepting one.
  // Optionally pulse start with other operands at k == inject_at.
  task automatic wait_done(input int inject_at);
    int             k;
    logic [2*W-1:0] res;
    logic           dz;
    int             lat;
    k = 0;
    while (!bus.done && k < 200) begin
      @(negedge clk);
      k++;
      if (k == inject_at) begin
        bus.start = 1'b1;
        bus.op    = 2'b11;
        bus.a     = 32'd1000;
        bus.b     = 32'd3;
      end else if (k == inject_at + 1) begin
        bus.start = 1'b0;
      end
    end
    check("done_seen", 64'(bus.done), 64'd1);
    if (bus.done && exp_q.size() > 0) begin
      res = exp_q.pop_front();
      dz  = exp_dz_q.pop_front();
      lat = exp_lat_q.pop_front();
      check("latency", 64'(k), 64'(lat));
      check("result", bus.result, res);
      check("hilo_en", 64'(bus.hilo_en), 64'(!dz));
      check("div_by_zero", 64'(bus.div_by_zero), 64'(dz));
      check("busy_at_done", 64'(bus.busy), 64'd0);
    end
  endtask

  // One idle cycle: the completion pulses must have dropped.
  task automatic idle_step();
    @(negedge clk);
    check("done_pulse", 64'(bus.done), 64'd0);
    check("hilo_en_pulse", 64'(bus.hilo_en), 64'd0);
  endtask

  // Stimulus and final report.
  initial begin
    logic [2*W-1:0] held;
    logic [1:0]     rop;
    logic [W-1:0]   ra, rb;
    clr       = 1'b0;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(negedge clk);
    check("rst_state", 64'(state), 64'(IDLE));
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_hilo_en", 64'(bus.hilo_en), 64'd0);
    check("rst_dbz", 64'(bus.div_by_zero), 64'd0);
    check("rst_result", bus.result, 64'd0);
    clr = 1'b1;
    @(negedge clk);

    // Directed cases.
    launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_done(-5); idle_step();
    launch(2'b00, 32'hFFFF_FFFD, 32'd7);         wait_done(-5); idle_step();
    launch(2'b00, 32'h8000_0000, 32'h8000_0000); wait_done(-5); idle_step();
    launch(2'b10, 32'hFFFF_FFF9, 32'd2);         wait_done(-5); idle_step();
    launch(2'b11, 32'd100, 32'd7);               wait_done(-5); idle_step();
    launch(2'b10, 32'h8000_0000, 32'hFFFF_FFFF); wait_done(-5); idle_step();
    launch(2'b11, 32'h0000_1234, 32'd0);         wait_done(-5); idle_step();

    // start pulsed mid-RUN is dropped; result persists while idle.
    launch(2'b01, 32'd123456, 32'd789);          wait_done(10); idle_step();
    held = 64'd123456 * 64'd789;
    repeat (40) @(negedge clk);
    check("ignored_start_done", 64'(bus.done), 64'd0);
    check("result_hold", bus.result, held);

    // start held in the DONE cycle: accepted back-to-back.
    launch(2'b11, 32'd1000, 32'd9);              wait_done(-5);
    launch(2'b00, 32'hFFFF_FF00, 32'h0001_0000); wait_done(-5); idle_step();

    // Async reset during RUN aborts with no load enable.
    launch(2'b01, 32'hDEAD_BEEF, 32'h0BAD_F00D);
    repeat (11) @(negedge clk);
    clr = 1'b0;
    #1;
    check("abort_state", 64'(state), 64'(IDLE));
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_done", 64'(bus.done), 64'd0);
    check("abort_hilo_en", 64'(bus.hilo_en), 64'd0);
    check("abort_result", bus.result, 64'd0);
    exp_q.delete();
    exp_dz_q.delete();
    exp_lat_q.delete();
    repeat (3) begin
      @(negedge clk);
      check("abort_hold_hilo_en", 64'(bus.hilo_en), 64'd0);
    end
    clr = 1'b1;
    repeat (40) @(negedge clk);
    check("abort_no_late_en", 64'(bus.hilo_en), 64'd0);
    launch(2'b01, 32'd5, 32'd6);                 wait_done(-5); idle_step();

    // Randomized operations, some back-to-back.
    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 15));
        default: ;
      endcase
      launch(rop, ra, rb);
      wait_done(-5);
      if ($urandom_range(0, 1) == 0) idle_step();
    end
    idle_step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
